// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared defaults and idle FSM encoding for the I2C line conditioner
package i2c_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_IDLE_CYCLES   = 1000;

    localparam logic [0:0] ST_BUSY = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// rtl/i2c_glitch_filter.sv - synchroniser plus persistence filter for one open-drain line
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic glitch
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser chain; idles high like the released bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Accept a new level only after it persists FILTER_CYCLES clocks; flag a spike that falls back early.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt   <= 1'b1;
            cnt    <= '0;
            glitch <= 1'b0;
        end else begin
            glitch <= 1'b0;
            if (s != filt) begin
                if (cnt == CNT_LAST) begin
                    filt <= s;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt    <= '0;
                glitch <= (cnt != '0);
            end
        end
    end

endmodule

// File: rtl/i2c_line_conditioner.sv
// rtl/i2c_line_conditioner.sv - filtered SCL/SDA, START/STOP pulses and bus-idle tracking
module i2c_line_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int IDLE_CYCLES   = DEF_IDLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic SCL_i,
    input  logic SDA_i,
    output logic SCL_f,
    output logic SDA_f,
    output logic start_p,
    output logic stop_p,
    output logic bus_idle,
    output logic glitch_p
);

    localparam int ICW = $clog2(IDLE_CYCLES + 1);
    localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(IDLE_CYCLES);
    localparam logic [ICW-1:0] IDLE_LAST  = ICW'(IDLE_CYCLES - 1);

    logic           scl_glitch;
    logic           sda_glitch;
    logic           SCL_q;
    logic           SDA_q;
    logic [ICW-1:0] idle_cnt;
    logic [0:0]     state;
    logic           lines_high;
    logic           idle_reached;

    i2c_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl_filter (
        .clk    (clk),
        .rst    (rst),
        .raw    (SCL_i),
        .filt   (SCL_f),
        .glitch (scl_glitch)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda_filter (
        .clk    (clk),
        .rst    (rst),
        .raw    (SDA_i),
        .filt   (SDA_f),
        .glitch (sda_glitch)
    );

    // Simultaneous spikes on both lines merge into one pulse.
    assign glitch_p = scl_glitch | sda_glitch;

    assign lines_high   = SCL_f & SDA_f;
    // The counter is about to reach IDLE_CYCLES on this clock (or already has).
    assign idle_reached = lines_high && (idle_cnt >= IDLE_LAST);

    // SDA edges while SCL stays high on both sides of the edge are START/STOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            SCL_q   <= 1'b1;
            SDA_q   <= 1'b1;
            start_p <= 1'b0;
            stop_p  <= 1'b0;
        end else begin
            SCL_q   <= SCL_f;
            SDA_q   <= SDA_f;
            start_p <= SCL_q & SCL_f & SDA_q & ~SDA_f;
            stop_p  <= SCL_q & SCL_f & ~SDA_q & SDA_f;
        end
    end

    // Saturating count of clocks with both lines released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (start_p || !lines_high) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LIMIT) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Idle FSM: a STOP or a long quiet period frees the bus; START or SCL low claims it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_BUSY;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (stop_p || (idle_reached && !start_p)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (start_p || !SCL_f) begin
                        state <= ST_BUSY;
                    end
                end
            endcase
        end
    end

    assign bus_idle = (state == ST_IDLE);

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb/tb_i2c_line_conditioner.sv - scoreboard bench for the I2C line conditioner
module tb_i2c_line_conditioner;

    logic clk;
    logic rst;
    logic SCL_i;
    logic SDA_i;
    logic SCL_f;
    logic SDA_f;
    logic start_p;
    logic stop_p;
    logic bus_idle;
    logic glitch_p;

    i2c_line_conditioner dut (
        .clk      (clk),
        .rst      (rst),
        .SCL_i    (SCL_i),
        .SDA_i    (SDA_i),
        .SCL_f    (SCL_f),
        .SDA_f    (SDA_f),
        .start_p  (start_p),
        .stop_p   (stop_p),
        .bus_idle (bus_idle),
        .glitch_p (glitch_p)
    );

    // Event kinds: 0 SCL_f change, 1 SDA_f change, 2 start_p, 3 stop_p, 4 glitch_p, 5 bus_idle change
    typedef struct {
        int   kind;
        int   cyc;
        logic val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int at, input logic val);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every output event pops the scoreboard and must match kind, cycle and level.
    initial begin
        logic [5:0] cur;
        logic [5:0] prev;
        logic       hit;
        exp_t       e;
        prev = 6'b0;
        forever begin
            @(negedge clk);
            cur = {bus_idle, glitch_p, stop_p, start_p, SDA_f, SCL_f};
            if (mon_en) begin
                for (int k = 0; k < 6; k++) begin
                    hit = (k == 0 || k == 1 || k == 5) ? (cur[k] != prev[k]) : cur[k];
                    if (hit) begin
                        n_checks++;
                        if (q.size() == 0) begin
                            $display("FAIL unexpected_event: kind %0d level %b at cycle %0d, expected none", k, cur[k], cyc);
                        end else begin
                            e = q.pop_front();
                            if (e.kind == k && e.cyc == cyc && e.val == cur[k]) begin
                                n_pass++;
                            end else begin
                                $display("FAIL event: got kind %0d level %b cycle %0d, expected kind %0d level %b cycle %0d",
                                         k, cur[k], cyc, e.kind, e.val, e.cyc);
                            end
                        end
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        int c;
        rst   = 1'b0;
        SCL_i = 1'b1;
        SDA_i = 1'b1;
        tick(3);
        chk("rst_SCL_f", SCL_f, 1'b1);
        chk("rst_SDA_f", SDA_f, 1'b1);
        chk("rst_start_p", start_p, 1'b0);
        chk("rst_stop_p", stop_p, 1'b0);
        chk("rst_glitch_p", glitch_p, 1'b0);
        chk("rst_bus_idle", bus_idle, 1'b0);

        // Idle declared exactly IDLE_CYCLES clocks after reset release with lines high
        mon_en = 1'b1;
        rst    = 1'b1;
        c      = cyc;
        expect_ev(5, c + 1000, 1'b1);
        tick(999);
        chk("idle_before_limit", bus_idle, 1'b0);
        tick(1);
        chk("idle_at_limit", bus_idle, 1'b1);

        // SDA spike of FILTER_CYCLES-1 clocks is rejected
        tick(10);
        c = cyc;
        expect_ev(4, c + 6, 1'b1);
        SDA_i = 1'b0;
        tick(3);
        SDA_i = 1'b1;
        tick(10);
        chk("spike_SDA_f", SDA_f, 1'b1);

        // START
        c = cyc;
        expect_ev(1, c + 6, 1'b0);
        expect_ev(2, c + 7, 1'b1);
        expect_ev(5, c + 8, 1'b0);
        SDA_i = 1'b0;
        tick(12);
        chk("start_busy", bus_idle, 1'b0);

        // STOP
        c = cyc;
        expect_ev(1, c + 6, 1'b1);
        expect_ev(3, c + 7, 1'b1);
        expect_ev(5, c + 8, 1'b1);
        SDA_i = 1'b1;
        tick(12);
        chk("stop_idle", bus_idle, 1'b1);

        // Both lines fall together: no START, bus busy via SCL low
        c = cyc;
        expect_ev(0, c + 6, 1'b0);
        expect_ev(1, c + 6, 1'b0);
        expect_ev(5, c + 7, 1'b0);
        SCL_i = 1'b0;
        SDA_i = 1'b0;
        tick(12);

        // SCL clock pulse with SDA low, then SDA changes while SCL low
        c = cyc;
        expect_ev(0, c + 6, 1'b1);
        SCL_i = 1'b1;
        tick(12);
        c = cyc;
        expect_ev(0, c + 6, 1'b0);
        SCL_i = 1'b0;
        tick(12);
        c = cyc;
        expect_ev(1, c + 6, 1'b1);
        SDA_i = 1'b1;
        tick(12);

        // Simultaneous 2-clock spikes on both lines give one glitch pulse
        c = cyc;
        expect_ev(4, c + 5, 1'b1);
        SCL_i = 1'b1;
        SDA_i = 1'b0;
        tick(2);
        SCL_i = 1'b0;
        SDA_i = 1'b1;
        tick(12);
        chk("dual_spike_SCL_f", SCL_f, 1'b0);

        // Reset mid-byte with SCL_f low
        c = cyc;
        expect_ev(0, c + 1, 1'b1);
        rst   = 1'b0;
        SCL_i = 1'b1;
        SDA_i = 1'b1;
        tick(1);
        chk("mid_rst_SCL_f", SCL_f, 1'b1);
        chk("mid_rst_SDA_f", SDA_f, 1'b1);
        chk("mid_rst_start_p", start_p, 1'b0);
        chk("mid_rst_stop_p", stop_p, 1'b0);
        chk("mid_rst_glitch_p", glitch_p, 1'b0);
        chk("mid_rst_bus_idle", bus_idle, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(20);
        chk("post_rst_bus_idle", bus_idle, 1'b0);

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
